// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared DDS types and width/limit defaults
package dds_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_WAVE_WIDTH   = 16;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/wave_mem_arbiter_if.sv
// rtl/wave_mem_arbiter_if.sv - bus write path, playback read path and RAM port bundle
interface wave_mem_arbiter_if #(
    parameter int ADDR_WIDTH = dds_pkg::DEF_ADDR_WIDTH,
    parameter int WAVE_WIDTH = dds_pkg::DEF_WAVE_WIDTH
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WAVE_WIDTH-1:0] wr_dat;
    logic                  wr_full;
    logic                  wr_done;
    logic                  wr_ovf;
    logic                  wr_ovf_clr;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_vld;
    logic [WAVE_WIDTH-1:0] rd_dat;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WAVE_WIDTH-1:0] ram_wdat;
    logic [WAVE_WIDTH-1:0] ram_rdat;

    // master: requesters plus the RAM macro; slave: the arbiter
    modport master (
        output wr_en, wr_addr, wr_dat, wr_ovf_clr, rd_req, rd_addr, ram_rdat,
        input  wr_full, wr_done, wr_ovf, rd_gnt, rd_vld, rd_dat,
               ram_en, ram_we, ram_addr, ram_wdat
    );

    modport slave (
        input  wr_en, wr_addr, wr_dat, wr_ovf_clr, rd_req, rd_addr, ram_rdat,
        output wr_full, wr_done, wr_ovf, rd_gnt, rd_vld, rd_dat,
               ram_en, ram_we, ram_addr, ram_wdat
    );
endinterface

// File: rtl/wave_mem_arbiter.sv
// rtl/wave_mem_arbiter.sv - single-port waveform RAM arbiter, read priority with bounded write starvation
module wave_mem_arbiter
    import dds_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WAVE_WIDTH   = DEF_WAVE_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    wave_mem_arbiter_if.slave  bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t            state, state_next;
    logic [CW-1:0]         starve_cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [WAVE_WIDTH-1:0] buf_dat;
    logic                  buf_load;
    logic                  gnt, commit;
    logic                  ovf, ovf_next;
    logic                  done, vld;

    always_comb begin
        state_next = state;
        cnt_next   = starve_cnt;
        buf_load   = 1'b0;
        gnt        = 1'b0;
        commit     = 1'b0;
        // everything combinational stays quiet while reset is held
        if (wb_rst_n_i) begin
            case (state)
                IDLE: begin
                    gnt = bus.rd_req;
                    if (bus.wr_en) begin
                        buf_load   = 1'b1;
                        state_next = PEND;
                    end
                end
                PEND: begin
                    if (bus.rd_req && (starve_cnt < LIMIT)) begin
                        gnt      = 1'b1;
                        cnt_next = starve_cnt + 1'b1;
                    end else begin
                        commit     = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ovf_next = ovf;
        if (bus.wr_ovf_clr)
            ovf_next = 1'b0;
        // set beats clear; a write on the commit cycle is still a drop
        if (bus.wr_en && (state == PEND))
            ovf_next = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            starve_cnt <= '0;
            buf_addr   <= '0;
            buf_dat    <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
            vld        <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
            ovf        <= ovf_next;
            done       <= commit;
            vld        <= gnt;
            if (buf_load) begin
                buf_addr <= bus.wr_addr;
                buf_dat  <= bus.wr_dat;
            end
        end
    end

    assign bus.rd_gnt   = gnt;
    assign bus.ram_en   = gnt | commit;
    assign bus.ram_we   = commit;
    assign bus.ram_addr = gnt ? bus.rd_addr : buf_addr;
    assign bus.ram_wdat = buf_dat;
    assign bus.rd_dat   = bus.ram_rdat;
    assign bus.rd_vld   = vld;
    assign bus.wr_full  = (state == PEND);
    assign bus.wr_done  = done;
    assign bus.wr_ovf   = ovf;

endmodule

// File: tb/tb_wave_mem_arbiter.sv
// tb/tb_wave_mem_arbiter.sv - randomized scoreboard bench for wave_mem_arbiter
module tb_wave_mem_arbiter;

    localparam int AW  = 5;
    localparam int WW  = 16;
    localparam int LIM = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wave_mem_arbiter_if #(.ADDR_WIDTH(AW), .WAVE_WIDTH(WW)) bus ();

    wave_mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .WAVE_WIDTH  (WW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus)
    );

    // RAM macro: registered read, write on enable
    logic [WW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdat;
            else            bus.ram_rdat      <= ram[bus.ram_addr];
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // reference model: a memory image, a one-entry write buffer and the reads it has waited through
    logic [WW-1:0]       ref_mem [DEPTH];
    bit                  pend = 0;
    logic [AW-1:0]       p_addr;
    logic [WW-1:0]       p_dat;
    int                  p_reads = 0;
    int                  p_age = 0;
    bit                  m_ovf = 0, m_done = 0, m_vld = 0;
    logic [WW-1:0]       rd_q [$];
    logic [AW+WW-1:0]    wr_q [$];
    bit                  gnt_q = 0;

    always @(negedge clk) begin
        bit exp_gnt, exp_commit;
        logic [WW-1:0] d;
        logic [AW+WW-1:0] w;
        gnt_q = bus.rd_gnt;
        if (!rst_n) begin
            chk("rst_gnt", {31'b0, bus.rd_gnt}, 0);
            chk("rst_en",  {31'b0, bus.ram_en}, 0);
            chk("rst_we",  {31'b0, bus.ram_we}, 0);
            pend = 0; p_reads = 0; p_age = 0;
            m_ovf = 0; m_done = 0; m_vld = 0;
            rd_q.delete(); wr_q.delete();
        end else begin
            exp_gnt    = bus.rd_req && (!pend || p_reads < LIM);
            exp_commit = pend && !exp_gnt;
            chk("rd_gnt",   {31'b0, bus.rd_gnt}, {31'b0, exp_gnt});
            chk("ram_we",   {31'b0, bus.ram_we}, {31'b0, exp_commit});
            chk("ram_en",   {31'b0, bus.ram_en}, {31'b0, exp_gnt || exp_commit});
            chk("wr_full",  {31'b0, bus.wr_full}, {31'b0, pend});
            chk("wr_done",  {31'b0, bus.wr_done}, {31'b0, m_done});
            chk("wr_ovf",   {31'b0, bus.wr_ovf}, {31'b0, m_ovf});
            chk("rd_vld",   {31'b0, bus.rd_vld}, {31'b0, m_vld});
            if (bus.rd_gnt)
                chk("rd_addr", {27'b0, bus.ram_addr}, {27'b0, bus.rd_addr});
            if (bus.rd_vld) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    d = rd_q.pop_front();
                    chk("rd_dat", {16'b0, bus.rd_dat}, {16'b0, d});
                end
            end
            if (bus.ram_we) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", {27'b0, bus.ram_addr}, {27'b0, w[AW+WW-1:WW]});
                    chk("wr_dat",  {16'b0, bus.ram_wdat}, {16'b0, w[WW-1:0]});
                    chk("starve_bound", {31'b0, p_age <= LIM + 1}, 1);
                end
            end
            // advance model across the coming edge
            if (exp_gnt) rd_q.push_back(ref_mem[bus.rd_addr]);
            m_vld  = exp_gnt;
            m_done = exp_commit;
            if (bus.wr_en && pend)    m_ovf = 1;
            else if (bus.wr_ovf_clr)  m_ovf = 0;
            if (pend) begin
                p_age++;
                if (exp_gnt) p_reads++;
                if (exp_commit) begin
                    ref_mem[p_addr] = p_dat;
                    pend = 0;
                end
            end else if (bus.wr_en) begin
                pend = 1; p_addr = bus.wr_addr; p_dat = bus.wr_dat;
                p_reads = 0; p_age = 1;
                wr_q.push_back({bus.wr_addr, bus.wr_dat});
            end
        end
    end

    // a read left ungranted is held with the same address
    task automatic step(input bit we, input logic [AW-1:0] wa, input logic [WW-1:0] wd,
                        input bit rr, input logic [AW-1:0] ra, input bit clr);
        @(posedge clk); #1;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_dat = wd; bus.wr_ovf_clr = clr;
        if (!(bus.rd_req && !gnt_q)) begin
            bus.rd_req = rr; bus.rd_addr = ra;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = WW'(i * 16'h0101) ^ 16'h5a5a;
            ref_mem[i] = WW'(i * 16'h0101) ^ 16'h5a5a;
        end
        ram[7] = 16'h1234; ref_mem[7] = 16'h1234;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_dat = '0; bus.wr_ovf_clr = 0;
        bus.rd_req = 0; bus.rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2);
        step(1, 5'd3, 16'hBEEF, 0, '0, 0);
        idle(3);
        step(0, '0, '0, 1, 5'd7, 0);
        idle(2);
        step(1, 5'd5, 16'hA5A5, 1, 5'd1, 0);
        for (int i = 0; i < 8; i++) step(0, '0, '0, 1, AW'(i), 0);
        idle(3);
        step(1, 5'd2, 16'h1111, 0, '0, 0);
        step(1, 5'd9, 16'h9999, 0, '0, 0);
        idle(3);
        step(0, '0, '0, 0, '0, 1);
        idle(2);
        step(1, 5'd4, 16'h4444, 1, 5'd6, 0);
        idle(3);
        step(0, '0, '0, 1, 5'd4, 0);
        step(0, '0, '0, 1, 5'd2, 0);
        idle(2);
        step(1, 5'd8, 16'h8888, 1, 5'd0, 0);
        step(0, '0, '0, 1, 5'd1, 0);
        #1 rst_n = 0;
        idle(2);
        #1 rst_n = 1;
        idle(2);
        step(0, '0, '0, 1, 5'd8, 0);
        idle(2);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) == 0, AW'($urandom), WW'($urandom),
                 $urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 15) == 0);
        idle(6);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
